// File: rtl/lcd_timing_ctrl.sv
// Dot/line timing generator: prescaler, dot/LY counters, LCD mode, drawline strobe, VBlank/STAT requests.
// Optional STAT interrupt edge logic is built only when LCD_STAT_IRQ_EN is defined.
module lcd_timing_ctrl #(
  parameter int CLKS_PER_DOT  = 1,
  parameter int DOTS_PER_LINE = 456,
  parameter int OAM_DOTS      = 80,
  parameter int XFER_DOTS     = 172,
  parameter int VISIBLE_LINES = 144,
  parameter int TOTAL_LINES   = 154
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       lcd_enable,
  input  logic [7:0] lyc,
  input  logic [3:0] stat_sel,
  output logic       drawline,
  output logic       frame_start,
  output logic [7:0] ly,
  output logic [1:0] mode,
  output logic       lyc_match,
  output logic       vblank_irq,
  output logic       stat_irq
);

  localparam int PW = (CLKS_PER_DOT > 1) ? $clog2(CLKS_PER_DOT) : 1;

  localparam logic [PW-1:0] PRE_LAST = PW'(CLKS_PER_DOT - 1);
  localparam logic [8:0]    DOT_LAST = 9'(DOTS_PER_LINE - 1);
  localparam logic [8:0]    OAM_END  = 9'(OAM_DOTS);
  localparam logic [8:0]    XFER_END = 9'(OAM_DOTS + XFER_DOTS);
  localparam logic [7:0]    LY_LAST  = 8'(TOTAL_LINES - 1);
  localparam logic [7:0]    VIS_END  = 8'(VISIBLE_LINES);

  localparam logic [1:0] MODE_HBLANK = 2'd0;
  localparam logic [1:0] MODE_VBLANK = 2'd1;
  localparam logic [1:0] MODE_OAM    = 2'd2;
  localparam logic [1:0] MODE_XFER   = 2'd3;

  logic [PW-1:0] presc_q, presc_d;
  logic [8:0]    dot_q, dot_d;
  logic [7:0]    ly_q, ly_d;
  logic [1:0]    mode_q, mode_d;
  logic          en_q;
  logic          lyc_match_q, lyc_match_d;
  logic          drawline_q, drawline_d;
  logic          frame_start_q, frame_start_d;
  logic          vblank_q, vblank_d;
  logic          dot_tick;
  logic          lcd_start;

  // en_q is the enable seen last clock; a 0->1 step restarts the frame at (0,0).
  assign lcd_start = lcd_enable && !en_q;

  always_comb begin
    presc_d  = presc_q;
    dot_d    = dot_q;
    ly_d     = ly_q;
    dot_tick = 1'b0;
    if (!lcd_enable) begin
      presc_d = '0;
      dot_d   = '0;
      ly_d    = '0;
    end else if (en_q) begin
      if (presc_q == PRE_LAST) begin
        presc_d  = '0;
        dot_tick = 1'b1;
        if (dot_q == DOT_LAST) begin
          dot_d = '0;
          ly_d  = (ly_q == LY_LAST) ? 8'd0 : ly_q + 8'd1;
        end else begin
          dot_d = dot_q + 9'd1;
        end
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  always_comb begin
    mode_d = MODE_HBLANK;
    if (lcd_enable) begin
      if (ly_d >= VIS_END)       mode_d = MODE_VBLANK;
      else if (dot_d < OAM_END)  mode_d = MODE_OAM;
      else if (dot_d < XFER_END) mode_d = MODE_XFER;
      else                       mode_d = MODE_HBLANK;
    end
  end

  assign drawline_d    = dot_tick && (dot_d == OAM_END) && (ly_d < VIS_END);
  assign frame_start_d = lcd_start || (dot_tick && (dot_d == 9'd0) && (ly_d == 8'd0));
  assign vblank_d      = dot_tick && (dot_d == 9'd0) && (ly_d == VIS_END);
  assign lyc_match_d   = (ly_q == lyc);

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q       <= '0;
      dot_q         <= '0;
      ly_q          <= '0;
      mode_q        <= MODE_HBLANK;
      en_q          <= 1'b0;
      lyc_match_q   <= 1'b0;
      drawline_q    <= 1'b0;
      frame_start_q <= 1'b0;
      vblank_q      <= 1'b0;
    end else begin
      presc_q       <= presc_d;
      dot_q         <= dot_d;
      ly_q          <= ly_d;
      mode_q        <= mode_d;
      en_q          <= lcd_enable;
      lyc_match_q   <= lyc_match_d;
      drawline_q    <= drawline_d;
      frame_start_q <= frame_start_d;
      vblank_q      <= vblank_d;
    end
  end

`ifdef LCD_STAT_IRQ_EN
  logic stat_line;
  logic stat_line_q;
  logic stat_irq_q;

  // Sources are ORed so overlapping conditions keep the line high and block a second request.
  assign stat_line = en_q && ((stat_sel[3] && lyc_match_q) ||
                              (stat_sel[2] && (mode_q == MODE_OAM)) ||
                              (stat_sel[1] && (mode_q == MODE_VBLANK)) ||
                              (stat_sel[0] && (mode_q == MODE_HBLANK)));

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_line_q <= 1'b0;
      stat_irq_q  <= 1'b0;
    end else begin
      stat_line_q <= stat_line;
      stat_irq_q  <= lcd_enable && stat_line && !stat_line_q;
    end
  end

  assign stat_irq = stat_irq_q;
`else
  logic unused_stat_sel;
  assign unused_stat_sel = ^stat_sel;
  assign stat_irq        = 1'b0;
`endif

  assign drawline    = drawline_q;
  assign frame_start = frame_start_q;
  assign ly          = ly_q;
  assign mode        = mode_q;
  assign lyc_match   = lyc_match_q;
  assign vblank_irq  = vblank_q;

endmodule

// File: doc/lcd_timing_ctrl.md
Name: lcd_timing_ctrl

Overview:
Dot/line timing generator that sits directly upstream of the background renderer. It produces the per-line `drawline` strobe that advances the renderer. It also tracks the LY line counter and the LCD mode, and raises the VBlank and STAT interrupt requests. It is fed by LCDC.7 (LCD enable), LYC and the STAT interrupt-select bits; its `ly`/`mode`/`lyc_match` outputs back the LY and STAT read values.

Parameters:
CLKS_PER_DOT, 1, system clocks per dot; must be >=1.
DOTS_PER_LINE, 456, dots per scanline.
OAM_DOTS, 80, length of mode 2 (OAM search) in dots.
XFER_DOTS, 172, length of mode 3 (pixel transfer) in dots.
VISIBLE_LINES, 144, visible lines (LY 0..143).
TOTAL_LINES, 154, total lines per frame, VBlank included.

Ports:
clk  input  1  system clock, the data-bus clock.
reset  input  1  synchronous, active-high.
lcd_enable  input  1  LCDC bit 7.
lyc  input  8  LY compare value (FF45).
stat_sel  input  4  STAT[6:3] = {lyc, mode2, mode1, mode0} interrupt selects.
drawline  output  1  one-clock strobe: render one line.
frame_start  output  1  one-clock strobe at line 0, dot 0.
ly  output  8  current line, 0..TOTAL_LINES-1.
mode  output  2  0=HBlank, 1=VBlank, 2=OAM, 3=Transfer.
lyc_match  output  1  registered ly==lyc.
vblank_irq  output  1  one-clock request, IF bit 0.
stat_irq  output  1  one-clock request, IF bit 1.

Behaviour:
- All outputs are registered. Reset values: ly=0, mode=0, lyc_match=0; all strobes and IRQs 0. Internal prescaler=0, dot=0.
- Prescaler counts 0..CLKS_PER_DOT-1. `dot_tick` asserts when it wraps. The dot counter (9 bits) and line counter advance only on `dot_tick`.
- dot wraps at DOTS_PER_LINE-1 to 0. ly then increments and wraps at TOTAL_LINES-1 to 0.
- Mode decode, applied in the same cycle the counters update:
  - ly >= VISIBLE_LINES: mode 1.
  - else dot < OAM_DOTS: mode 2.
  - else dot < OAM_DOTS+XFER_DOTS: mode 3.
  - else: mode 0.
- drawline: a single clock on the tick where dot becomes OAM_DOTS and ly < VISIBLE_LINES. This gives exactly 144 pulses per frame, none during VBlank.
- frame_start: a single clock when (ly,dot) becomes (0,0) by wrap, and one clock after the lcd_enable rising edge.
- vblank_irq: a single clock when ly becomes VISIBLE_LINES at dot 0.
- lyc_match: updates one clock after any change of ly or lyc.
- LCD off (lcd_enable=0):
  - Prescaler, dot and ly are held at 0; mode=0.
  - No strobes or IRQs are produced.
  - lyc_match still tracks ly==lyc.
- LCD on: takes effect on the first clock lcd_enable is sampled 1. Line 0 starts at dot 0, mode 2.
- LCD switched off mid-frame: counters clear on the next clock; no vblank_irq is issued.
- reset while running: same as the reset values, regardless of lcd_enable. Counting restarts on the clock after reset deasserts if lcd_enable=1.
- lyc change mid-line: the compare re-evaluates immediately (1-clock latency).

Optional Feature:
LCD_STAT_IRQ_EN.
- Defined:
  - Internal `stat_line` = (stat_sel[3]&lyc_match) | (stat_sel[2]&mode==2) | (stat_sel[1]&mode==1) | (stat_sel[0]&mode==0).
  - stat_irq pulses one clock on each 0->1 edge of stat_line. Continuous overlap of sources ("STAT blocking") yields no second pulse.
  - stat_line is forced to 0 while the LCD is off.
- Undefined: stat_irq is tied 0, stat_sel is ignored, and no edge-detect logic is built.

Test Plan:
1. reset=1 for 3 clocks, then lcd_enable=1 with defaults -> frame_start at clk 1 after enable; mode=2 at ly=0; first drawline 80 clocks later; mode=3 for 172 clocks, then mode=0 for 204 clocks; ly=1 at clock 456.
2. Run a full frame -> exactly 144 drawline pulses; vblank_irq once at ly=144 dot 0 (clock 65664); mode=1 through ly 153; ly wraps to 0 at clock 70224 with frame_start.
3. CLKS_PER_DOT=4 -> first drawline at clock 320; line period 1824 clocks.
4. lyc=5, stat_sel=4'b1000 (macro defined) -> lyc_match rises one clock after ly=5; one stat_irq pulse; lyc_match clears at ly=6.
5. stat_sel=4'b1001, lyc=143 (macro defined) -> one stat_irq at ly=143 entry; no extra pulse at HBlank of line 143 (blocking); pulse at each HBlank of other lines.
6. lcd_enable dropped at ly=100 dot 200 -> next clock ly=0, mode=0, no further drawline; re-enable -> frame_start, mode=2, ly=0.
